// File: rtl/alu_share_sched.sv
// Two requesters share one 4-bit-operand ALU; each owns a private 8-bit accumulator.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_sched #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 2 * DATA_W
) (
    input  logic              Clock,
    input  logic              Reset_b,
    input  logic [1:0]        Req,
    input  logic [2:0]        Func0,
    input  logic [DATA_W-1:0] Data0,
    input  logic [2:0]        Func1,
    input  logic [DATA_W-1:0] Data1,
    output logic [1:0]        Ack,
    output logic [ACC_W-1:0]  Result,
    output logic              Grant_id,
    output logic              Busy,
    output logic [ACC_W-1:0]  Acc0,
    output logic [ACC_W-1:0]  Acc1
);

    localparam logic [2:0] F_ADD0 = 3'b000;
    localparam logic [2:0] F_ADD1 = 3'b001;
    localparam logic [2:0] F_SEXT = 3'b010;
    localparam logic [2:0] F_OR   = 3'b011;
    localparam logic [2:0] F_AND  = 3'b100;
    localparam logic [2:0] F_SHL  = 3'b101;
    localparam logic [2:0] F_MUL  = 3'b110;
    localparam logic [2:0] F_HOLD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              id_q;
    logic              winner;
    logic [2:0]        func_q;
    logic [DATA_W-1:0] data_q;
    logic              ack_q;
    logic              latch_en;
    logic              exec_en;
    logic              ack_set;
    logic              ack_clr;
    logic [ACC_W-1:0]  acc_sel;
    logic [ACC_W-1:0]  alu_r;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum;

    // Arbitration: only consulted in IDLE when at least one request is present.
`ifdef ALU_SCHED_RR_EN
    logic rr_ptr;

    always_comb begin
        if (Req == 2'b11) winner = rr_ptr;
        else              winner = Req[1];
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b)      rr_ptr <= 1'b0;
        else if (latch_en) rr_ptr <= ~rr_ptr;
    end
`else
    always_comb winner = ~Req[0];
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        exec_en   = 1'b0;
        ack_set   = 1'b0;
        ack_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (|Req) begin
                    latch_en  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                exec_en   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                // Ack is always shown for at least one cycle, even if Req already dropped.
                if (!ack_q) begin
                    ack_set = 1'b1;
                end else if (!Req[id_q]) begin
                    ack_clr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acc_sel = id_q ? Acc1 : Acc0;
        op_a    = data_q;
        op_b    = acc_sel[DATA_W-1:0];
        sum     = {1'b0, op_a} + {1'b0, op_b};
        alu_r   = acc_sel;
        case (func_q)
            F_ADD0, F_ADD1: alu_r = ACC_W'(sum);
            F_SEXT:         alu_r = {{(ACC_W-DATA_W){op_b[DATA_W-1]}}, op_b};
            F_OR:           alu_r = ACC_W'(|{op_a, op_b});
            F_AND:          alu_r = ACC_W'(&{op_a, op_b});
            F_SHL: begin
                if (32'(op_b) >= 32'(ACC_W)) alu_r = '0;
                else                         alu_r = ACC_W'(op_a) << op_b;
            end
            F_MUL:          alu_r = ACC_W'(op_a) * ACC_W'(op_b);
            F_HOLD:         alu_r = acc_sel;
            default:        alu_r = acc_sel;
        endcase
    end

    // Operands are captured at the grant edge; later Func/Data changes have no effect.
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            id_q   <= 1'b0;
            func_q <= '0;
            data_q <= '0;
            ack_q  <= 1'b0;
            Result <= '0;
            Acc0   <= '0;
            Acc1   <= '0;
        end else begin
            if (latch_en) begin
                id_q   <= winner;
                func_q <= winner ? Func1 : Func0;
                data_q <= winner ? Data1 : Data0;
            end
            if (exec_en) begin
                Result <= alu_r;
                if (id_q) Acc1 <= alu_r;
                else      Acc0 <= alu_r;
            end
            if (ack_set)      ack_q <= 1'b1;
            else if (ack_clr) ack_q <= 1'b0;
        end
    end

    assign Ack      = {ack_q & id_q, ack_q & ~id_q};
    assign Grant_id = id_q;
    assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench for alu_share_sched: directed ops push expectations, a monitor checks each Ack.
module tb_alu_share_sched;

    logic       Clock = 1'b0;
    logic       Reset_b;
    logic [1:0] Req;
    logic [2:0] Func0, Func1;
    logic [3:0] Data0, Data1;
    logic [1:0] Ack;
    logic [7:0] Result, Acc0, Acc1;
    logic       Grant_id, Busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] ack;
        logic       grant;
        logic [7:0] result;
        logic [7:0] acc0;
        logic [7:0] acc1;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_acc0, m_acc1;
    logic [1:0] ack_prev = 2'b00;

    alu_share_sched dut (
        .Clock   (Clock),
        .Reset_b (Reset_b),
        .Req     (Req),
        .Func0   (Func0),
        .Data0   (Data0),
        .Func1   (Func1),
        .Data1   (Data1),
        .Ack     (Ack),
        .Result  (Result),
        .Grant_id(Grant_id),
        .Busy    (Busy),
        .Acc0    (Acc0),
        .Acc1    (Acc1)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_op(input bit id, input logic [7:0] res);
        if (id) m_acc1 = res;
        else    m_acc0 = res;
        sb.push_back('{ack: (id ? 2'b10 : 2'b01), grant: id, result: res,
                       acc0: m_acc0, acc1: m_acc1});
    endtask

    // Monitor: every rising Ack pops one expectation.
    always @(negedge Clock) begin
        if (!Reset_b) begin
            ack_prev = 2'b00;
        end else begin
            if (Ack != 2'b00 && ack_prev == 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", Ack, 2'b00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_ack",    Ack,      e.ack);
                    check("sb_grant",  Grant_id, e.grant);
                    check("sb_result", Result,   e.result);
                    check("sb_acc0",   Acc0,     e.acc0);
                    check("sb_acc1",   Acc1,     e.acc1);
                end
            end
            ack_prev = Ack;
        end
    end

    task automatic set_cmd(input bit id, input logic [2:0] f, input logic [3:0] d);
        if (id) begin Func1 = f; Data1 = d; end
        else    begin Func0 = f; Data0 = d; end
    endtask

    task automatic do_op(input bit id, input logic [2:0] f, input logic [3:0] d,
                         input logic [7:0] res, input int hold, input bit scramble);
        int cyc = 0;
        @(negedge Clock);
        set_cmd(id, f, d);
        expect_op(id, res);
        Req[id] = 1'b1;
        do begin
            @(negedge Clock);
            cyc++;
            if (scramble && cyc == 1) set_cmd(id, ~f, ~d);
        end while (Ack[id] !== 1'b1 && cyc < 12);
        check("ack_latency", cyc, 3);
        for (int h = 0; h < hold; h++) begin
            @(negedge Clock);
            check("ack_hold", Ack, id ? 2'b10 : 2'b01);
            check("busy_hold", Busy, 1'b1);
        end
        Req[id] = 1'b0;
        @(negedge Clock);
        check("ack_release", Ack, 2'b00);
        check("busy_release", Busy, 1'b0);
    endtask

    task automatic contention();
        logic [3:0] g_exp;
        int         cyc;
`ifdef ALU_SCHED_RR_EN
        g_exp = 4'b1010;
`else
        g_exp = 4'b0000;
`endif
        set_cmd(1'b0, 3'b000, 4'h1);
        set_cmd(1'b1, 3'b000, 4'h2);
        for (int k = 0; k < 4; k++) begin
            if (g_exp[k]) expect_op(1'b1, m_acc1 + 8'h02);
            else          expect_op(1'b0, m_acc0 + 8'h01);
        end
        @(negedge Clock);
        Req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                @(negedge Clock);
                cyc++;
            end while (Ack == 2'b00 && cyc < 12);
            check("arb_grant", Grant_id, g_exp[k]);
            Req = Req & ~Ack;
            @(negedge Clock);
            Req = (k == 3) ? 2'b00 : 2'b11;
        end
        repeat (2) @(negedge Clock);
        check("arb_idle", Busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset_b = 1'b0;
        Req     = 2'b00;
        Func0   = 3'b000; Data0 = 4'h0;
        Func1   = 3'b000; Data1 = 4'h0;
        m_acc0  = 8'h00;
        m_acc1  = 8'h00;
        #3;
        check("rst_ack", Ack, 2'b00);
        check("rst_result", Result, 8'h00);
        check("rst_grant", Grant_id, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_acc0", Acc0, 8'h00);
        check("rst_acc1", Acc1, 8'h00);
        @(negedge Clock);
        Reset_b = 1'b1;

        // Requester 0 chain, hand-computed results
        do_op(1'b0, 3'b000, 4'h5, 8'h05, 0, 1'b0);
        do_op(1'b0, 3'b001, 4'hC, 8'h11, 0, 1'b0);
        do_op(1'b0, 3'b010, 4'h7, 8'h01, 0, 1'b0);
        do_op(1'b0, 3'b101, 4'h3, 8'h06, 0, 1'b1);
        do_op(1'b0, 3'b110, 4'hF, 8'h5A, 0, 1'b0);

        // Requester 1: negative sign-extension and hold code
        do_op(1'b1, 3'b000, 4'hA, 8'h0A, 0, 1'b0);
        do_op(1'b1, 3'b010, 4'h3, 8'hFA, 0, 1'b0);
        do_op(1'b1, 3'b111, 4'h5, 8'hFA, 0, 1'b0);

        // Req[1] withdrawn during EXEC: op completes, Ack lasts one cycle
        @(negedge Clock);
        set_cmd(1'b1, 3'b000, 4'h1);
        expect_op(1'b1, 8'h0B);
        Req[1] = 1'b1;
        @(negedge Clock);
        Req[1] = 1'b0;
        @(negedge Clock);
        check("early_drop_ack_wait", Ack, 2'b00);
        @(negedge Clock);
        check("early_drop_ack_hi", Ack, 2'b10);
        @(negedge Clock);
        check("early_drop_ack_lo", Ack, 2'b00);

        // Req[0] held three cycles past Ack: no second operation
        do_op(1'b0, 3'b000, 4'h1, 8'h0B, 3, 1'b0);
        repeat (3) @(negedge Clock);
        check("no_second_op", Acc0, m_acc0);

        // AND/OR, shift boundary, carry out of the adder
        do_op(1'b0, 3'b100, 4'hF, 8'h00, 0, 1'b0);
        do_op(1'b0, 3'b000, 4'hF, 8'h0F, 0, 1'b0);
        do_op(1'b0, 3'b100, 4'hF, 8'h01, 0, 1'b0);
        do_op(1'b0, 3'b000, 4'h9, 8'h0A, 0, 1'b0);
        do_op(1'b0, 3'b101, 4'h1, 8'h00, 0, 1'b0);
        do_op(1'b0, 3'b000, 4'hF, 8'h0F, 0, 1'b0);
        do_op(1'b0, 3'b000, 4'hF, 8'h1E, 0, 1'b0);
        do_op(1'b0, 3'b011, 4'h0, 8'h01, 0, 1'b0);

        // Asynchronous reset in the middle of EXEC
        @(negedge Clock);
        set_cmd(1'b0, 3'b000, 4'h3);
        Req[0] = 1'b1;
        @(posedge Clock);
        #1;
        check("abort_busy_exec", Busy, 1'b1);
        #1;
        Reset_b = 1'b0;
        Req     = 2'b00;
        #1;
        check("abort_ack", Ack, 2'b00);
        check("abort_busy", Busy, 1'b0);
        check("abort_acc0", Acc0, 8'h00);
        check("abort_acc1", Acc1, 8'h00);
        check("abort_result", Result, 8'h00);
        m_acc0 = 8'h00;
        m_acc1 = 8'h00;
        repeat (2) @(negedge Clock);
        Reset_b = 1'b1;
        repeat (3) @(negedge Clock);
        check("post_abort_ack", Ack, 2'b00);
        check("post_abort_acc0", Acc0, 8'h00);

        // Both requesters competing
        contention();

        repeat (3) @(negedge Clock);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
